// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, fetch-stage state encoding, reset PC.
package mips_pkg;

    localparam logic [5:0]  OP_BEQ           = 6'b000100;
    localparam logic [5:0]  OP_BNE           = 6'b000101;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_DROP
    } fetch_state_e;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                  input logic [15:0] imm16);
        return pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: 2-bit saturating counters, one read port and one training port.
// Only compiled when IF_BHT_EN is defined.
`ifdef IF_BHT_EN
module if_bht #(
    parameter int BHT_BITS = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BHT_BITS-1:0] rd_idx,
    output logic                rd_taken,
    input  logic                upd_valid,
    input  logic                upd_taken,
    input  logic [BHT_BITS-1:0] upd_idx
);

    localparam int ENTRIES = 1 << BHT_BITS;

    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d [ENTRIES];

    always_comb begin
        ctr_d = ctr_q;
        if (upd_valid) begin
            if (upd_taken && (ctr_q[upd_idx] != 2'b11)) begin
                ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
            end else if (!upd_taken && (ctr_q[upd_idx] != 2'b00)) begin
                ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
        end
    end

    // Counters start weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_taken = ctr_q[rd_idx][1];

endmodule
`endif

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: PC, single-outstanding imem handshake, two-deep buffering.
// Optional branch prediction is enabled by defining IF_BHT_EN.
module if_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          BHT_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        upd_valid,
    input  logic        upd_taken,
    input  logic [31:0] upd_pc,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc4,
    output logic [31:0] fetch_instr,
    output logic        fetch_pred
);

    fetch_state_e state_q, state_d;

    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_pc4_q, pending_pc4_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc4_q, fetch_pc4_d;
    logic [31:0] fetch_instr_q, fetch_instr_d;
    logic        fetch_pred_q, fetch_pred_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_pc4_q, hold_pc4_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_pred_q, hold_pred_d;

    logic        granted;
    logic        rsp_accept;
    logic        consume;
    logic        is_branch;
    logic        bht_taken;
    logic        pred_taken;
    logic [31:0] rsp_pc;
    logic [31:0] rsp_target;
    logic        unused_bits;

    assign granted    = imem_req && imem_gnt;
    assign rsp_accept = (state_q == FETCH_WAIT) && imem_rvalid;
    assign consume    = fetch_valid_q && !stall;
    assign rsp_pc     = pending_pc4_q - 32'd4;
    assign is_branch  = (imem_rdata[31:26] == OP_BEQ) || (imem_rdata[31:26] == OP_BNE);
    assign rsp_target = branch_target(pending_pc4_q, imem_rdata[15:0]);
    assign pred_taken = is_branch && bht_taken;

`ifdef IF_BHT_EN
    if_bht #(
        .BHT_BITS (BHT_BITS)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (rsp_pc[BHT_BITS+1:2]),
        .rd_taken  (bht_taken),
        .upd_valid (upd_valid),
        .upd_taken (upd_taken),
        .upd_idx   (upd_pc[BHT_BITS+1:2])
    );
    assign unused_bits = ^{rsp_pc[31:BHT_BITS+2], rsp_pc[1:0],
                           upd_pc[31:BHT_BITS+2], upd_pc[1:0]};
`else
    assign bht_taken   = 1'b0;
    assign unused_bits = ^{rsp_pc, rsp_pc[BHT_BITS+1:2], upd_valid, upd_taken, upd_pc};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect that coincides with the response it would orphan needs no DROP: the
    // stale word is simply not captured and no request remains outstanding.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH_REQ: begin
                if (granted) state_d = redirect ? FETCH_DROP : FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rvalid)   state_d = FETCH_REQ;
                else if (redirect) state_d = FETCH_DROP;
            end
            FETCH_DROP: begin
                if (imem_rvalid) state_d = FETCH_REQ;
            end
            default: state_d = FETCH_REQ;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == FETCH_REQ) && !hold_valid_q;
        imem_addr = pc_q;
    end

    // Hold is always empty while a request is outstanding, so an arriving word never
    // competes with a hold-to-slot refill.
    always_comb begin
        pc_d          = pc_q;
        pending_pc4_d = pending_pc4_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc4_d   = fetch_pc4_q;
        fetch_instr_d = fetch_instr_q;
        fetch_pred_d  = fetch_pred_q;
        hold_valid_d  = hold_valid_q;
        hold_pc4_d    = hold_pc4_q;
        hold_instr_d  = hold_instr_q;
        hold_pred_d   = hold_pred_q;

        if (granted) begin
            pc_d          = pc_q + 32'd4;
            pending_pc4_d = pc_q + 32'd4;
        end

        if (consume) begin
            if (hold_valid_q) begin
                fetch_pc4_d   = hold_pc4_q;
                fetch_instr_d = hold_instr_q;
                fetch_pred_d  = hold_pred_q;
                hold_valid_d  = 1'b0;
            end else begin
                fetch_valid_d = 1'b0;
            end
        end

        if (rsp_accept) begin
            if (pred_taken) pc_d = rsp_target;
            if (!fetch_valid_q || !stall) begin
                fetch_valid_d = 1'b1;
                fetch_pc4_d   = pending_pc4_q;
                fetch_instr_d = imem_rdata;
                fetch_pred_d  = pred_taken;
            end else begin
                hold_valid_d  = 1'b1;
                hold_pc4_d    = pending_pc4_q;
                hold_instr_d  = imem_rdata;
                hold_pred_d   = pred_taken;
            end
        end

        if (redirect) begin
            pc_d          = redirect_pc;
            fetch_valid_d = 1'b0;
            hold_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pending_pc4_q <= 32'd0;
            fetch_valid_q <= 1'b0;
            fetch_pc4_q   <= 32'd0;
            fetch_instr_q <= 32'd0;
            fetch_pred_q  <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_pc4_q    <= 32'd0;
            hold_instr_q  <= 32'd0;
            hold_pred_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pending_pc4_q <= pending_pc4_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc4_q   <= fetch_pc4_d;
            fetch_instr_q <= fetch_instr_d;
            fetch_pred_q  <= fetch_pred_d;
            hold_valid_q  <= hold_valid_d;
            hold_pc4_q    <= hold_pc4_d;
            hold_instr_q  <= hold_instr_d;
            hold_pred_q   <= hold_pred_d;
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_pc4   = fetch_pc4_q;
    assign fetch_instr = fetch_instr_q;
    assign fetch_pred  = fetch_pred_q;

endmodule
